counter_ctrl: RTL
=================

Name: counter_ctrl

Overview:
- Programmable controller that sequences a 4-bit-class counter datapath: up or down counting, limit, prescaler, and one-shot or auto-reload operation.
- Accepts a configuration over a valid/ready handshake, then runs on start and supports pause and abort.
- Emits per-step and terminal-count strobes.
- Sits between software/config logic and the counter so counting is synchronous and controlled, replacing free-running ripple operation.

Parameters:
- WIDTH, 4, count and limit width.
- PRE_W, 4, prescaler width.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- cfg_valid  in  1  config offered
- cfg_ready  out  1  config can be accepted
- cfg_limit  in  WIDTH  terminal value L
- cfg_prescale  in  PRE_W  step every P+1 cycles
- cfg_dir  in  1  0 = up, 1 = down
- cfg_reload  in  1  1 = auto-reload, 0 = one-shot
- start  in  1  begin counting
- pause  in  1  level; freeze while high
- abort  in  1  return to IDLE
- count  out  WIDTH  current count
- tick  out  1  one-cycle pulse, coincident with each count update
- tc  out  1  one-cycle pulse at terminal count
- busy  out  1  high in RUN or PAUSE
- done  out  1  high in DONE

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE.
  - count, the prescale counter pcnt, and the stored L, P, dir and reload all clear to 0.
  - tick = 0, tc = 0, busy = 0, done = 0, cfg_ready = 1.
- States:
  - IDLE, RUN, PAUSE and DONE.
  - busy = (RUN or PAUSE).
  - done = DONE.
  - cfg_ready = (IDLE or DONE), decoded combinationally from state.
- Start value S and terminal value T:
  - Up: S = 0, T = L.
  - Down: S = L, T = 0.
- Config accept:
  - Occurs on cfg_valid & cfg_ready at a clock edge.
  - Stores L, P, dir and reload; count <= S computed from the new config; state <= IDLE, which clears done.
  - Config accept beats start in the same cycle; start is ignored that cycle.
  - cfg_valid is ignored while cfg_ready = 0 and has no effect on stored config.
- Start:
  - In IDLE or DONE, with no abort and no config accept that cycle: state <= RUN, count <= S, pcnt <= 0.
  - start is ignored in RUN and PAUSE.
- Step condition: state == RUN, pause == 0, pcnt == P.
  - On a step: pcnt <= 0, tick <= 1.
  - Otherwise in RUN with pause == 0: pcnt <= pcnt + 1.
  - P = 0 steps every cycle.
- On a step:
  - If count != T: count moves by ±1 per dir.
  - If count == T: tc <= 1.
    - Reload = 1: count <= S, remain in RUN.
    - Reload = 0: state <= DONE, count holds T.
  - Period is (L+1)*(P+1) cycles.
  - L = 0 with reload gives count fixed at 0 and tc every P+1 cycles.
  - Arithmetic is modulo 2^WIDTH, but T is always reached before wrap.
- Pause:
  - pause = 1 in RUN: state <= PAUSE; no step that cycle; pcnt and count frozen.
  - In PAUSE with pause = 0: state <= RUN; stepping resumes next cycle with pcnt preserved, so no step is lost or duplicated.
- Abort:
  - Highest synchronous priority.
  - From any state: state <= IDLE, count <= S, pcnt <= 0, tick and tc not asserted.
  - Stored config is kept.
- Strobe and output registering:
  - tick and tc are registered and high for exactly one cycle, aligned with the edge that updates count or state.
  - At a terminal step, tick and tc are both high.
- Reset asserted mid-run: all outputs take their reset values without waiting for a clock edge; deassertion resumes in IDLE.

Test Plan:
- Reset; cfg L=3, P=0, up, one-shot; start at edge T0.
  - count = 0 after T0; count = 1, 2, 3 after T1, T2, T3, with tick each edge.
  - After T4: tc = 1 and tick = 1 for one cycle, done = 1, busy = 0, count holds 3.
- cfg L=2, P=2, down, reload; start.
  - count sequence 2, 1, 0, 2, ..., each value held 3 cycles.
  - tc pulses every 9 cycles; busy stays 1; done never asserts.
- L=5, P=1, up; assert pause for 7 cycles when count = 2.
  - count and pcnt frozen, state PAUSE.
  - After release, count = 3 exactly as many cycles later as if no pause had occurred, counted in active cycles.
- cfg_valid during RUN:
  - cfg_ready = 0 and config unchanged.
  - After DONE, new config accepted and done clears.
  - cfg_valid and start together in IDLE: config taken, state stays IDLE.
- abort in PAUSE: next cycle IDLE, busy = 0, count = S, no tc.
  - reset pulled low mid-RUN between clock edges: count = 0 and busy = 0 immediately.
- L=0, P=3, reload: count stays 0, tc every 4 cycles.
  - abort then start again: tc period restarts from 0.

Source files
------------

// File: rtl/counter_ctrl.sv
// Sequencer for a small synchronous counter: up/down counting to a programmable limit,
// prescaled stepping, one-shot or auto-reload, with pause/abort and registered strobes.
module counter_ctrl #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [PRE_W-1:0] cfg_prescale,
  input  logic             cfg_dir,
  input  logic             cfg_reload,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [PRE_W-1:0] PCNT_ONE = PRE_W'(1);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [PRE_W-1:0] pcnt_q,   pcnt_d;
  logic [WIDTH-1:0] lim_q,    lim_d;
  logic [PRE_W-1:0] pre_q,    pre_d;
  logic             dir_q,    dir_d;
  logic             reload_q, reload_d;
  logic             tick_q,   tick_d;
  logic             tc_q,     tc_d;

  logic             idle_like;
  logic             cfg_take;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] term_val;

  // Start and terminal values follow the direction of the stored configuration.
  always_comb begin
    idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    cfg_take  = cfg_valid && idle_like;
    start_val = dir_q ? lim_q : '0;
    term_val  = dir_q ? '0 : lim_q;
  end

  // NOTE: every variable gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pcnt_d   = pcnt_q;
    lim_d    = lim_q;
    pre_d    = pre_q;
    dir_d    = dir_q;
    reload_d = reload_q;
    tick_d   = 1'b0;
    tc_d     = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      count_d = start_val;
      pcnt_d  = '0;
    end else if (cfg_take) begin
      // A config beat wins over start in the same cycle and leaves the block idle.
      lim_d    = cfg_limit;
      pre_d    = cfg_prescale;
      dir_d    = cfg_dir;
      reload_d = cfg_reload;
      count_d  = cfg_dir ? cfg_limit : '0;
      pcnt_d   = '0;
      state_d  = ST_IDLE;
    end else if (start && idle_like) begin
      state_d = ST_RUN;
      count_d = start_val;
      pcnt_d  = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (pcnt_q == pre_q) begin
            pcnt_d = '0;
            tick_d = 1'b1;
            if (count_q == term_val) begin
              tc_d = 1'b1;
              if (reload_q) count_d = start_val;
              else          state_d = ST_DONE;
            end else begin
              count_d = dir_q ? (count_q - CNT_ONE) : (count_q + CNT_ONE);
            end
          end else begin
            pcnt_d = pcnt_q + PCNT_ONE;
          end
        end
        ST_PAUSE: begin
          // Resuming costs one non-counting cycle; pcnt is untouched so no step is lost.
          if (!pause) state_d = ST_RUN;
        end
        default: begin
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the stored config is
  // reset too because start/terminal values are derived from it straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      pcnt_q   <= '0;
      lim_q    <= '0;
      pre_q    <= '0;
      dir_q    <= 1'b0;
      reload_q <= 1'b0;
      tick_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      pcnt_q   <= pcnt_d;
      lim_q    <= lim_d;
      pre_q    <= pre_d;
      dir_q    <= dir_d;
      reload_q <= reload_d;
      tick_q   <= tick_d;
      tc_q     <= tc_d;
    end
  end

  assign count     = count_q;
  assign tick      = tick_q;
  assign tc        = tc_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done      = (state_q == ST_DONE);
  assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);

endmodule
